// File: rtl/ras_spill_engine.sv
// ras_spill_engine
//   Return-address stack held in an on-chip circular buffer. A spill/fill
//   engine moves two-entry blocks between the bottom of the buffer and
//   backing memory, so the core sees a much deeper stack.
//
//   Build option: define RAS_CIPHER_EN to route every block through an
//   external cipher (encrypt on spill, decrypt on fill). When it is not
//   defined, plaintext goes straight to memory and the cph_* outputs are 0.
//
//   Ports
//     clk, arst_n          clock, async active-low reset
//     push/ret/addr_in     call push / return check from the pipeline
//     rdy, full, empty     front-side status (rdy is combinational)
//     mismatch             one-cycle pulse after a wrong or empty return
//     ovf                  sticky: the oldest entry was overwritten
//     blocks               number of blocks currently held in memory
//     mem_*                single-outstanding valid/ack memory port
//     cph_*                cipher request/result handshakes
//     cfg_wr/addr/din      config writes: 0 = ena, 1 = memory base
//     ena                  RAS enable
module ras_spill_engine #(
    parameter int W            = 32,
    parameter int DEPTH        = 64,
    parameter int FILL_THRESH  = 48,
    parameter int EMPTY_THRESH = 16,
    parameter int MAX_BLOCKS   = 1024
) (
    input  logic                            clk,
    input  logic                            arst_n,
    input  logic                            push,
    input  logic                            ret,
    input  logic [W-1:0]                    addr_in,
    output logic                            rdy,
    output logic                            full,
    output logic                            empty,
    output logic                            mismatch,
    output logic                            ovf,
    output logic [$clog2(MAX_BLOCKS+1)-1:0] blocks,
    output logic                            mem_req,
    output logic                            mem_we,
    output logic [31:0]                     mem_addr,
    output logic [W-1:0]                    mem_wdata,
    input  logic                            mem_ack,
    input  logic [W-1:0]                    mem_rdata,
    output logic                            cph_valid,
    output logic                            cph_mode,
    input  logic                            cph_ready,
    output logic [2*W-1:0]                  cph_din,
    input  logic                            cph_ovalid,
    output logic                            cph_oready,
    input  logic [2*W-1:0]                  cph_dout,
    input  logic                            cfg_wr,
    input  logic [2:0]                      cfg_addr,
    input  logic [31:0]                     cfg_din,
    output logic                            ena
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(MAX_BLOCKS + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] FILL_C  = CW'(FILL_THRESH);
    localparam logic [CW-1:0] EMPTY_C = CW'(EMPTY_THRESH);
    localparam logic [BW-1:0] MAX_C   = BW'(MAX_BLOCKS);

    typedef enum logic [3:0] {
        S_IDLE, S_SP_POP0, S_SP_POP1, S_SP_CPH, S_SP_CPW, S_SP_WR0, S_SP_WR1,
        S_FL_RD1, S_FL_RD0, S_FL_CPH, S_FL_CPW, S_FL_PUSH1, S_FL_PUSH0
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   top_q, top_d;      // next free slot above the youngest entry
    logic [PW-1:0]   bot_q, bot_d;      // oldest entry
    logic [CW-1:0]   count_q, count_d;
    logic [BW-1:0]   blocks_q, blocks_d;
    logic [W-1:0]    lo_q, lo_d, hi_q, hi_d;
    logic [31:0]     base_q, base_d;
    logic            ena_q, ena_d;
    logic            ovf_q, ovf_d;
    logic            mismatch_q, mismatch_d;
    logic [W-1:0]    stk_q [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(DEPTH - 1) : p - PW'(1);
    endfunction

    logic            blk_full, blk_zero;
    logic            front_ok, do_ret, do_push, f_inc, f_dec;
    logic [PW-1:0]   top_m1, bot_m1;
    logic [CW-1:0]   cnt_front;
    logic            bpop_ok, bpush_ok;
    logic            b_pop, b_push;
    logic [W-1:0]    b_wdata;
    logic [31:0]     blk_addr;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign blk_full = (blocks_q == MAX_C);
    assign blk_zero = (blocks_q == '0);
    // Full with no room left in memory is the one case where a push is
    // still taken (it overwrites the oldest entry), so the core never stalls.
    assign rdy      = (~full & ~(empty & ~blk_zero)) | (full & blk_full);

    assign front_ok = rdy & ena_q;
    assign do_ret   = ret & front_ok;
    assign do_push  = push & ~ret & front_ok;
    assign f_inc    = do_push & ~full;
    assign f_dec    = do_ret & ~empty;
    assign top_m1   = ptr_dec(top_q);
    assign bot_m1   = ptr_dec(bot_q);

    // Back-side moves are checked against the count after this cycle's
    // front operation so both ends never touch the same slot.
    assign cnt_front = count_q + CW'(f_inc) - CW'(f_dec);
    assign bpop_ok   = (count_q - CW'(f_dec)) != '0;
    assign bpush_ok  = cnt_front < DEPTH_C;

    assign blk_addr  = base_q + (32'(blocks_q) << 3);

    assign mismatch = mismatch_q;
    assign ovf      = ovf_q;
    assign ena      = ena_q;
    assign blocks   = blocks_q;

`ifndef RAS_CIPHER_EN
    logic unused_cph;
    assign unused_cph = ^{cph_ready, cph_ovalid, cph_dout};
`endif

    // Spill/fill engine: next state and port outputs.
    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        blocks_d   = blocks_q;
        b_pop      = 1'b0;
        b_push     = 1'b0;
        b_wdata    = hi_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cph_valid  = 1'b0;
        cph_mode   = 1'b0;
        cph_din    = '0;
        cph_oready = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ena_q) begin
                    if (count_q > FILL_C && !blk_full)       state_d = S_SP_POP0;
                    else if (count_q < EMPTY_C && !blk_zero) state_d = S_FL_RD1;
                end
            end
            S_SP_POP0: if (bpop_ok) begin
                b_pop   = 1'b1;
                lo_d    = stk_q[bot_q];
                state_d = S_SP_POP1;
            end
            S_SP_POP1: if (bpop_ok) begin
                b_pop = 1'b1;
                hi_d  = stk_q[bot_q];
`ifdef RAS_CIPHER_EN
                state_d = S_SP_CPH;
`else
                state_d = S_SP_WR0;
`endif
            end
`ifdef RAS_CIPHER_EN
            S_SP_CPH: begin
                cph_valid = 1'b1;
                cph_din   = {hi_q, lo_q};
                if (cph_ready) state_d = S_SP_CPW;
            end
            S_SP_CPW: begin
                cph_oready = 1'b1;
                if (cph_ovalid) begin
                    {hi_d, lo_d} = cph_dout;
                    state_d      = S_SP_WR0;
                end
            end
            S_FL_CPH: begin
                cph_valid = 1'b1;
                cph_mode  = 1'b1;
                cph_din   = {hi_q, lo_q};
                if (cph_ready) state_d = S_FL_CPW;
            end
            S_FL_CPW: begin
                cph_oready = 1'b1;
                if (cph_ovalid) begin
                    {hi_d, lo_d} = cph_dout;
                    state_d      = S_FL_PUSH1;
                end
            end
`endif
            S_SP_WR0: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = blk_addr;
                mem_wdata = lo_q;
                if (mem_ack) state_d = S_SP_WR1;
            end
            S_SP_WR1: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = blk_addr + 32'd4;
                mem_wdata = hi_q;
                if (mem_ack) begin
                    blocks_d = blocks_q + BW'(1);
                    state_d  = S_IDLE;
                end
            end
            // blocks still counts the block being fetched, so its words
            // sit just below base + 8*blocks.
            S_FL_RD1: begin
                mem_req  = 1'b1;
                mem_addr = blk_addr - 32'd4;
                if (mem_ack) begin
                    hi_d    = mem_rdata;
                    state_d = S_FL_RD0;
                end
            end
            S_FL_RD0: begin
                mem_req  = 1'b1;
                mem_addr = blk_addr - 32'd8;
                if (mem_ack) begin
                    lo_d = mem_rdata;
`ifdef RAS_CIPHER_EN
                    state_d = S_FL_CPH;
`else
                    state_d = S_FL_PUSH1;
`endif
                end
            end
            S_FL_PUSH1: if (bpush_ok) begin
                b_push  = 1'b1;
                b_wdata = hi_q;
                state_d = S_FL_PUSH0;
            end
            S_FL_PUSH0: if (bpush_ok) begin
                b_push   = 1'b1;
                b_wdata  = lo_q;
                blocks_d = blocks_q - BW'(1);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Buffer pointers, flags and config.
    always_comb begin
        top_d      = top_q;
        bot_d      = bot_q;
        ovf_d      = ovf_q;
        mismatch_d = 1'b0;
        ena_d      = ena_q;
        base_d     = base_q;
        if (do_ret) begin
            if (empty) begin
                mismatch_d = 1'b1;
            end else begin
                top_d      = top_m1;
                mismatch_d = (stk_q[top_m1] != addr_in);
            end
        end
        if (do_push) begin
            top_d = ptr_inc(top_q);
            if (full) begin
                bot_d = ptr_inc(bot_q);
                ovf_d = 1'b1;
            end
        end
        // Overwrite only happens with memory full, when no spill can run
        // and fill pushes are blocked, so these never coincide with it.
        if (b_pop)       bot_d = ptr_inc(bot_q);
        else if (b_push) bot_d = bot_m1;
        count_d = cnt_front + CW'(b_push) - CW'(b_pop);
        if (cfg_wr) begin
            if (cfg_addr == 3'd0) ena_d = cfg_din[0];
            if (cfg_addr == 3'd1 && blk_zero && state_q == S_IDLE) base_d = cfg_din;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= S_IDLE;
            top_q      <= '0;
            bot_q      <= '0;
            count_q    <= '0;
            blocks_q   <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            base_q     <= '0;
            ena_q      <= 1'b1;
            ovf_q      <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            top_q      <= top_d;
            bot_q      <= bot_d;
            count_q    <= count_d;
            blocks_q   <= blocks_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            base_q     <= base_d;
            ena_q      <= ena_d;
            ovf_q      <= ovf_d;
            mismatch_q <= mismatch_d;
        end
    end

    // Entry storage: front push at top, fill push just below bottom.
    // Count guards keep the two write slots distinct.
    always_ff @(posedge clk) begin
        if (do_push) stk_q[top_q]  <= addr_in;
        if (b_push)  stk_q[bot_m1] <= b_wdata;
    end

endmodule
